// File: rtl/mul_arb.sv
// mul_arb: one iterative 16x16 shift-add multiplier shared round-robin between CPU registers and a HW req/ack port.
// Define MUL_SIGNED_EN to make CTL bit3 select two's-complement CPU multiplies.
module mul_arb #(
   parameter logic [13:0] BASE_ADDR = 14'hA8
) (
   input  logic        mclk,
   input  logic        puc_rst,
   input  logic [13:0] per_addr,
   input  logic [15:0] per_din,
   input  logic        per_en,
   input  logic [1:0]  per_we,
   output logic [15:0] per_dout,
   input  logic        hw_req,
   input  logic [15:0] hw_a,
   input  logic [15:0] hw_b,
   output logic        hw_ack,
   output logic [31:0] hw_res,
   output logic        irq_mul
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state_q, state_d;
   logic [15:0] opa_q, opa_d, opb_q, opb_d, reslo_q, reslo_d, reshi_q, reshi_d;
   logic [15:0] mplier_q, mplier_d;
   logic [31:0] mcand_q, mcand_d, acc_q, acc_d, hw_res_q, hw_res_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ie_q, ie_d, sgn_q, sgn_d, done_q, done_d, ovr_q, ovr_d, pend_q, pend_d;
   logic        last_q, last_d, owner_q, owner_d, neg_q, neg_d, ack_q, ack_d, irq_q, irq_d;
   logic [13:0] off;
   logic        rd, wr, ctl_wr, start_new, cpu_win, grant;
   logic [15:0] mag_a, mag_b;
   logic [31:0] prod;

   assign off       = per_addr - BASE_ADDR;
   assign rd        = per_en & (off < 14'd6) & (per_we == 2'b00);
   assign wr        = per_en & (off < 14'd6) & (per_we == 2'b11);
   assign ctl_wr    = wr & (off == 14'd4);
   assign start_new = ctl_wr & per_din[0] & ~pend_q;
   // last_q=1 means HW owned the multiplier last; a start arriving with hw_req is a tie the CPU wins a cycle later
   assign cpu_win   = pend_q & (~hw_req | last_q);
   assign grant     = pend_q | (hw_req & ~(start_new & last_q));
   assign mag_a     = (sgn_q & opa_q[15]) ? ~opa_q + 16'd1 : opa_q;
   assign mag_b     = (sgn_q & opb_q[15]) ? ~opb_q + 16'd1 : opb_q;
   assign prod      = neg_q ? ~acc_q + 32'd1 : acc_q;
`ifdef MUL_SIGNED_EN
   assign sgn_d     = ctl_wr ? per_din[3] : sgn_q;
`else
   assign sgn_d     = 1'b0;
`endif
   assign per_dout  = !rd ? 16'h0 :
                      off == 14'd0 ? opa_q :
                      off == 14'd1 ? opb_q :
                      off == 14'd2 ? reslo_q :
                      off == 14'd3 ? reshi_q :
                      off == 14'd4 ? {12'h0, sgn_q, ie_q, done_q, pend_q} :
                      {14'h0, owner_q, ovr_q};
   assign hw_ack    = ack_q;
   assign hw_res    = hw_res_q;
   assign irq_mul   = irq_q;

   always_comb begin
      state_d  = state_q;
      opa_d    = (wr && off == 14'd0) ? per_din : opa_q;
      opb_d    = (wr && off == 14'd1) ? per_din : opb_q;
      ie_d     = ctl_wr ? per_din[2] : ie_q;
      ovr_d    = (ctl_wr & per_din[0] & pend_q) | (ovr_q & ~(wr && off == 14'd5 && per_din[0]));
      pend_d   = pend_q | start_new;
      done_d   = done_q & ~start_new;
      reslo_d  = reslo_q;
      reshi_d  = reshi_q;
      hw_res_d = hw_res_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      neg_d    = neg_q;
      last_d   = last_q;
      ack_d    = 1'b0;
      case (state_q)
         IDLE: if (grant) begin
            owner_d  = ~cpu_win;
            neg_d    = cpu_win & sgn_q & (opa_q[15] ^ opb_q[15]);
            mcand_d  = {16'h0, cpu_win ? mag_a : hw_a};
            mplier_d = cpu_win ? mag_b : hw_b;
            acc_d    = 32'h0;
            cnt_d    = 4'd0;
            state_d  = RUN;
         end
         RUN: begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : 32'h0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 4'd1;
            state_d  = (cnt_q == 4'd15) ? DONE : RUN;
         end
         DONE: begin
            if (owner_q) begin
               hw_res_d = prod;
               ack_d    = 1'b1;
            end else begin
               {reshi_d, reslo_d} = prod;
               done_d   = 1'b1;
               pend_d   = 1'b0;
            end
            last_d  = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      irq_d = done_d & ie_d;
   end

   always_ff @(posedge mclk or posedge puc_rst)
      if (puc_rst) begin
         state_q  <= IDLE;
         opa_q    <= 16'h0;
         opb_q    <= 16'h0;
         reslo_q  <= 16'h0;
         reshi_q  <= 16'h0;
         mplier_q <= 16'h0;
         mcand_q  <= 32'h0;
         acc_q    <= 32'h0;
         hw_res_q <= 32'h0;
         cnt_q    <= 4'd0;
         ie_q     <= 1'b0;
         sgn_q    <= 1'b0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         pend_q   <= 1'b0;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         neg_q    <= 1'b0;
         ack_q    <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         reslo_q  <= reslo_d;
         reshi_q  <= reshi_d;
         mplier_q <= mplier_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         hw_res_q <= hw_res_d;
         cnt_q    <= cnt_d;
         ie_q     <= ie_d;
         sgn_q    <= sgn_d;
         done_q   <= done_d;
         ovr_q    <= ovr_d;
         pend_q   <= pend_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         neg_q    <= neg_d;
         ack_q    <= ack_d;
         irq_q    <= irq_d;
      end
endmodule

// File: tb/tb_mul_arb.sv
// tb_mul_arb: scoreboard bench for mul_arb; expected products are queued at stimulus time and popped on completion.
module tb_mul_arb;
   localparam logic [13:0] BASE = 14'hA8;
   logic        mclk = 1'b0, puc_rst = 1'b1, per_en = 1'b0, hw_req = 1'b0;
   logic [13:0] per_addr = '0;
   logic [15:0] per_din = '0, hw_a = '0, hw_b = '0, per_dout;
   logic [1:0]  per_we = '0;
   logic        hw_ack, irq_mul;
   logic [31:0] hw_res;
   int          checks = 0, errors = 0;
   logic [31:0] cpu_q[$], hw_q[$];

   mul_arb #(.BASE_ADDR(BASE)) dut (
      .mclk(mclk), .puc_rst(puc_rst), .per_addr(per_addr), .per_din(per_din), .per_en(per_en),
      .per_we(per_we), .per_dout(per_dout), .hw_req(hw_req), .hw_a(hw_a), .hw_b(hw_b),
      .hw_ack(hw_ack), .hw_res(hw_res), .irq_mul(irq_mul)
   );

   always #5 mclk = ~mclk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge mclk);
      #1;
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
      per_addr = BASE + 14'(a);
      per_din  = d;
      per_en   = 1'b1;
      per_we   = 2'b11;
      tick;
      per_en   = 1'b0;
      per_we   = 2'b00;
   endtask

   task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
      per_addr = BASE + 14'(a);
      per_en   = 1'b1;
      per_we   = 2'b00;
      #1 d     = per_dout;
      per_en   = 1'b0;
   endtask

   task automatic read_res(output logic [31:0] r);
      logic [15:0] lo, hi;
      bus_rd(3'd2, lo);
      bus_rd(3'd3, hi);
      r = {hi, lo};
   endtask

   task automatic wait_done(output int at);
      logic [15:0] d;
      at = 0;
      for (int k = 1; k <= 60 && at == 0; k++) begin
         tick;
         bus_rd(3'd4, d);
         if (d[1]) at = k;
      end
   endtask

   task automatic wait_ack(output int at, output logic [31:0] r);
      at = 0;
      r  = '0;
      for (int k = 1; k <= 60 && at == 0; k++) begin
         tick;
         if (hw_ack) begin
            at     = k;
            r      = hw_res;
            hw_req = 1'b0;
         end
      end
      hw_req = 1'b0;
   endtask

   task automatic do_reset;
      puc_rst = 1'b1;
      hw_req  = 1'b0;
      per_en  = 1'b0;
      per_we  = 2'b00;
      tick;
      tick;
      puc_rst = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      logic [15:0] d;
      logic [15:0] acc;
      puc_rst = 1'b1;
      repeat (3) tick;
      checks++;
      if ({hw_ack, irq_mul, hw_res} !== 34'h0) begin
         errors++;
         $display("FAIL reset_outputs got ack=%b irq=%b res=%h exp all 0", hw_ack, irq_mul, hw_res);
      end
      puc_rst = 1'b0;
      tick;
      acc = '0;
      for (int a = 0; a < 6; a++) begin
         bus_rd(3'(a), d);
         acc = acc | d;
      end
      checks++;
      if (acc !== 16'h0) begin
         errors++;
         $display("FAIL reset_regs got OR=%h exp 0000", acc);
      end
   endtask

   task automatic test_cpu_unsigned;
      logic [15:0] d;
      logic [31:0] r, exp;
      int at, bad;
      bus_wr(3'd0, 16'h1234);
      bus_wr(3'd1, 16'h5678);
      per_addr = BASE; per_din = 16'h1234; per_we = 2'b11; per_en = 1'b1;
      #1 checks++;
      if (per_dout !== 16'h0) begin errors++; $display("FAIL dout_on_write got %h exp 0000", per_dout); end
      per_en = 1'b0; per_addr = BASE + 14'd6; per_we = 2'b00; per_en = 1'b1;
      #1 checks++;
      if (per_dout !== 16'h0) begin errors++; $display("FAIL dout_unselected got %h exp 0000", per_dout); end
      per_en = 1'b0;
      bus_rd(3'd0, d);
      checks++;
      if (d !== 16'h1234) begin errors++; $display("FAIL opa_readback got %h exp 1234", d); end
      bus_wr(3'd4, 16'h0005);
      cpu_q.push_back(32'h0626_0060);
      at = 0;
      bad = 0;
      for (int k = 1; k <= 40 && at == 0; k++) begin
         tick;
         bus_rd(3'd4, d);
         if (d[1]) at = k;
         else if (!d[0]) bad++;
      end
      checks++;
      if (at != 18) begin errors++; $display("FAIL cpu_latency got %0d exp 18", at); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL cpu_busy got %0d idle cycles exp 0", bad); end
      checks++;
      if (d[2:0] !== 3'b110) begin errors++; $display("FAIL cpu_ctl_done got %b exp 110", d[2:0]); end
      checks++;
      if (irq_mul !== 1'b1) begin errors++; $display("FAIL cpu_irq got %b exp 1", irq_mul); end
      read_res(r);
      exp = cpu_q.size() != 0 ? cpu_q.pop_front() : 'x;
      checks++;
      if (r !== exp) begin errors++; $display("FAIL cpu_unsigned_res got %h exp %h", r, exp); end
      bus_wr(3'd4, 16'h0000);
      bus_rd(3'd4, d);
      checks++;
      if (irq_mul !== 1'b0 || d[1] !== 1'b1) begin
         errors++;
         $display("FAIL ie_clear got irq=%b done=%b exp irq=0 done=1", irq_mul, d[1]);
      end
   endtask

   task automatic test_hw_max;
      logic [31:0] r, exp;
      int at, acks;
      hw_a = 16'hFFFF;
      hw_b = 16'hFFFF;
      hw_req = 1'b1;
      hw_q.push_back(32'hFFFE_0001);
      wait_ack(at, r);
      exp = hw_q.size() != 0 ? hw_q.pop_front() : 'x;
      checks++;
      if (r !== exp) begin errors++; $display("FAIL hw_max_res got %h exp %h", r, exp); end
      checks++;
      if (at != 18) begin errors++; $display("FAIL hw_latency got %0d exp 18", at); end
      tick;
      checks++;
      if (hw_ack !== 1'b0 || hw_res !== 32'hFFFE_0001) begin
         errors++;
         $display("FAIL hw_ack_pulse got ack=%b res=%h exp ack=0 res=fffe0001", hw_ack, hw_res);
      end
      read_res(r);
      checks++;
      if (r !== 32'h0626_0060) begin errors++; $display("FAIL hw_cpu_res_untouched got %h exp 06260060", r); end
      acks = 0;
      repeat (20) begin tick; if (hw_ack) acks++; end
      checks++;
      if (acks != 0) begin errors++; $display("FAIL hw_extra_ack got %0d exp 0", acks); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] a, b;
      logic [31:0] r, exp;
      int at;
      for (int i = 0; i < 4; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         hw_a = a;
         hw_b = b;
         hw_req = 1'b1;
         hw_q.push_back({16'h0, a} * {16'h0, b});
         wait_ack(at, r);
         exp = hw_q.size() != 0 ? hw_q.pop_front() : 'x;
         checks++;
         if (r !== exp || at != 18) begin
            errors++;
            $display("FAIL b2b_%0d got %h at %0d exp %h at 18", i, r, at, exp);
         end
         tick;
      end
   endtask

   task automatic test_contention;
      logic [15:0] d, s5, s25;
      logic [31:0] r, exp, hr;
      int cpu_at, hw_at;
      do_reset;
      bus_wr(3'd0, 16'd300);
      bus_wr(3'd1, 16'd7);
      hw_a = 16'hABCD;
      hw_b = 16'h0010;
      hw_req = 1'b1;
      cpu_q.push_back(32'd2100);
      hw_q.push_back(32'h000A_BCD0);
      bus_wr(3'd4, 16'h0001);
      cpu_at = 0; hw_at = 0; s5 = 'x; s25 = 'x; hr = '0;
      for (int k = 1; k <= 60 && hw_at == 0; k++) begin
         tick;
         bus_rd(3'd4, d);
         if (d[1] && cpu_at == 0) cpu_at = k;
         if (k == 5) bus_rd(3'd5, s5);
         if (k == 25) bus_rd(3'd5, s25);
         if (hw_ack) begin hw_at = k; hr = hw_res; hw_req = 1'b0; end
      end
      hw_req = 1'b0;
      checks++;
      if (cpu_at != 18 || hw_at != 36) begin
         errors++;
         $display("FAIL tie_order got cpu=%0d hw=%0d exp cpu=18 hw=36", cpu_at, hw_at);
      end
      checks++;
      if (s5[1] !== 1'b0 || s25[1] !== 1'b1) begin
         errors++;
         $display("FAIL tie_owner got %b/%b exp 0/1", s5[1], s25[1]);
      end
      read_res(r);
      exp = cpu_q.size() != 0 ? cpu_q.pop_front() : 'x;
      checks++;
      if (r !== exp) begin errors++; $display("FAIL tie_cpu_res got %h exp %h", r, exp); end
      exp = hw_q.size() != 0 ? hw_q.pop_front() : 'x;
      checks++;
      if (hr !== exp) begin errors++; $display("FAIL tie_hw_res got %h exp %h", hr, exp); end
      bus_wr(3'd0, 16'd2);
      bus_wr(3'd1, 16'd3);
      cpu_q.push_back(32'd6);
      bus_wr(3'd4, 16'h0001);
      wait_done(cpu_at);
      read_res(r);
      exp = cpu_q.size() != 0 ? cpu_q.pop_front() : 'x;
      checks++;
      if (r !== exp || cpu_at != 18) begin
         errors++;
         $display("FAIL solo_cpu got %h at %0d exp %h at 18", r, cpu_at, exp);
      end
      bus_wr(3'd0, 16'd11);
      bus_wr(3'd1, 16'd13);
      hw_a = 16'd7;
      hw_b = 16'd9;
      hw_req = 1'b1;
      cpu_q.push_back(32'd143);
      hw_q.push_back(32'd63);
      bus_wr(3'd4, 16'h0001);
      cpu_at = 0; hw_at = 0;
      for (int k = 1; k <= 60 && cpu_at == 0; k++) begin
         tick;
         bus_rd(3'd4, d);
         if (d[1]) cpu_at = k;
         if (hw_ack) begin hw_at = k; hr = hw_res; hw_req = 1'b0; end
      end
      hw_req = 1'b0;
      checks++;
      if (hw_at != 17 || cpu_at != 35) begin
         errors++;
         $display("FAIL tie2_order got hw=%0d cpu=%0d exp hw=17 cpu=35", hw_at, cpu_at);
      end
      exp = hw_q.size() != 0 ? hw_q.pop_front() : 'x;
      checks++;
      if (hr !== exp) begin errors++; $display("FAIL tie2_hw_res got %h exp %h", hr, exp); end
      read_res(r);
      exp = cpu_q.size() != 0 ? cpu_q.pop_front() : 'x;
      checks++;
      if (r !== exp) begin errors++; $display("FAIL tie2_cpu_res got %h exp %h", r, exp); end
   endtask

   task automatic test_overrun;
      logic [15:0] d;
      logic [31:0] r, exp;
      int at;
      bus_wr(3'd0, 16'h0100);
      bus_wr(3'd1, 16'h0200);
      cpu_q.push_back(32'h0002_0000);
      bus_wr(3'd4, 16'h0005);
      repeat (3) tick;
      bus_wr(3'd0, 16'hFFFF);
      bus_wr(3'd4, 16'h0005);
      bus_rd(3'd5, d);
      checks++;
      if (d[0] !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", d[0]); end
      wait_done(at);
      read_res(r);
      exp = cpu_q.size() != 0 ? cpu_q.pop_front() : 'x;
      checks++;
      if (r !== exp || at != 13) begin
         errors++;
         $display("FAIL overrun_res got %h at %0d exp %h at 13", r, at, exp);
      end
      repeat (20) tick;
      bus_rd(3'd4, d);
      checks++;
      if (d[1:0] !== 2'b10 || irq_mul !== 1'b1) begin
         errors++;
         $display("FAIL overrun_single got ctl=%b irq=%b exp ctl=10 irq=1", d[1:0], irq_mul);
      end
      bus_wr(3'd5, 16'h0001);
      bus_rd(3'd5, d);
      checks++;
      if (d[0] !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b exp 0", d[0]); end
   endtask

   task automatic test_reset_mid;
      logic [15:0] d, acc;
      logic [31:0] r, exp;
      int acks, at;
      hw_a = 16'h1111;
      hw_b = 16'h2222;
      hw_req = 1'b1;
      acks = 0;
      repeat (6) begin tick; if (hw_ack) acks++; end
      puc_rst = 1'b1;
      #1 checks++;
      if ({hw_ack, irq_mul, hw_res} !== 34'h0) begin
         errors++;
         $display("FAIL rstmid_outputs got ack=%b irq=%b res=%h exp all 0", hw_ack, irq_mul, hw_res);
      end
      acc = '0;
      for (int a = 0; a < 6; a++) begin
         bus_rd(3'(a), d);
         acc = acc | d;
      end
      checks++;
      if (acc !== 16'h0) begin errors++; $display("FAIL rstmid_regs got OR=%h exp 0000", acc); end
      hw_req = 1'b0;
      tick;
      tick;
      puc_rst = 1'b0;
      repeat (25) begin tick; if (hw_ack) acks++; end
      checks++;
      if (acks != 0) begin errors++; $display("FAIL rstmid_no_ack got %0d exp 0", acks); end
      bus_wr(3'd0, 16'hBEEF);
      bus_wr(3'd1, 16'h0003);
      cpu_q.push_back(32'(16'hBEEF) * 32'd3);
      bus_wr(3'd4, 16'h0001);
      wait_done(at);
      read_res(r);
      exp = cpu_q.size() != 0 ? cpu_q.pop_front() : 'x;
      checks++;
      if (r !== exp || at != 18) begin
         errors++;
         $display("FAIL rstmid_fresh got %h at %0d exp %h at 18", r, at, exp);
      end
   endtask

   task automatic test_signed;
      logic [15:0] d;
      logic [31:0] r, exp;
      int at;
      bus_wr(3'd0, 16'hFFFF);
      bus_wr(3'd1, 16'h0002);
`ifdef MUL_SIGNED_EN
      cpu_q.push_back(32'hFFFF_FFFE);
`else
      cpu_q.push_back(32'h0001_FFFE);
`endif
      bus_wr(3'd4, 16'h0009);
      wait_done(at);
      bus_rd(3'd4, d);
      read_res(r);
      exp = cpu_q.size() != 0 ? cpu_q.pop_front() : 'x;
      checks++;
      if (r !== exp) begin errors++; $display("FAIL mode_bit3_res got %h exp %h", r, exp); end
      checks++;
`ifdef MUL_SIGNED_EN
      if (d[3] !== 1'b1) begin errors++; $display("FAIL ctl_bit3 got %b exp 1", d[3]); end
`else
      if (d[3] !== 1'b0) begin errors++; $display("FAIL ctl_bit3 got %b exp 0", d[3]); end
`endif
      cpu_q.push_back(32'h0001_FFFE);
      bus_wr(3'd4, 16'h0001);
      wait_done(at);
      read_res(r);
      exp = cpu_q.size() != 0 ? cpu_q.pop_front() : 'x;
      checks++;
      if (r !== exp) begin errors++; $display("FAIL unsigned_res got %h exp %h", r, exp); end
   endtask

   initial begin
      test_reset;
      test_cpu_unsigned;
      test_hw_max;
      test_back_to_back;
      test_contention;
      test_overrun;
      test_reset_mid;
      test_signed;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mul_arb.md
Name: mul_arb

Overview:
- Shared-multiplier peripheral on the openMSP430 peripheral bus.
- Owns one iterative 16x16 shift-add multiplier (one bit per cycle).
- Arbitrates that multiplier round-robin between two requesters:
  - CPU, via memory-mapped registers;
  - a hardware requester, via a req/ack port.
- Results are returned to the winning requester; an optional interrupt is raised on CPU completion.

Parameters:
- BASE_ADDR, 14'hA8, word address of first register; block decodes BASE_ADDR..BASE_ADDR+5.

Ports:
- mclk  in  1  clock
- puc_rst  in  1  asynchronous active-high reset
- per_addr  in  14  peripheral word address
- per_din  in  16  write data
- per_en  in  1  peripheral access enable
- per_we  in  2  byte write enables; 2'b11 = word write, 2'b00 = read
- per_dout  out  16  read data; 16'h0 when not selected
- hw_req  in  1  hardware request (level)
- hw_a  in  16  hardware operand A; stable while hw_req is high
- hw_b  in  16  hardware operand B; stable while hw_req is high
- hw_ack  out  1  one-cycle completion pulse
- hw_res  out  32  hardware result; valid while hw_ack is high, held afterwards
- irq_mul  out  1  CPU completion interrupt

Behaviour:
- Reset is puc_rst, asynchronous, active-high; clock is mclk.
- Register map (offset from BASE_ADDR). Writes require per_en & per_we==2'b11; reads require per_en & per_we==2'b00; other per_we values are ignored.
  - +0 OPA (rw)
  - +1 OPB (rw)
  - +2 RESLO (ro)
  - +3 RESHI (ro)
  - +4 CTL:
    - write bit0=1: start request;
    - bit2: IE (rw);
    - read bit0: busy, meaning CPU op pending or running;
    - read bit1: done.
  - +5 STAT (read):
    - bit0: overrun;
    - bit1: current owner (0=CPU, 1=HW);
    - write 1 to bit0 clears it.
- Reset values:
  - all registers 0; per_dout 0; hw_ack 0; hw_res 0; irq_mul 0;
  - FSM in IDLE;
  - last_owner=HW, so the CPU wins the first tie.
- CPU start write:
  - sets cpu_pend on that edge and clears done;
  - if cpu_pend is already set, the write is ignored and overrun is set.
- FSM:
  - IDLE:
    - if cpu_pend or hw_req, grant on this edge;
    - if both, the requester that is not last_owner wins;
    - load multiplicand/multiplier shift regs from OPA/OPB (CPU) or hw_a/hw_b (HW); clear accumulator; count=0; go to RUN;
    - on CPU grant, cpu_pend stays set until DONE.
  - RUN:
    - one add/shift per edge; count increments;
    - exits to DONE on the edge where count==15 (16 iterations).
  - DONE:
    - on the next edge, write the 32-bit product: RESLO/RESHI (CPU) or hw_res (HW);
    - CPU: set done, clear cpu_pend; HW: hw_ack=1 for exactly one cycle;
    - update last_owner; go to IDLE.
- Latency:
  - grant at edge G; result registered at G+17;
  - CPU uncontended: start write at E0, result/done at E18.
- Operands are captured at grant. OPA/OPB writes during RUN do not affect the running operation.
- HW handshake:
  - hw_req must drop in the cycle hw_ack is high;
  - if still high at the next IDLE sample, it is treated as a new request.
- hw_req dropping before ack: the operation completes, and hw_ack still pulses.
- irq_mul = done & IE, registered. It clears with done (next start write) or when IE is written 0.
- Product is an exact 32-bit unsigned result, with no truncation.
- Reset mid-operation: aborts the operation; no hw_ack, no result written, pend cleared.
- per_dout is combinational from the address decode, 16'h0 for any unselected or write cycle.

Optional Feature:
- MUL_SIGNED_EN defined:
  - CTL bit3 (rw) selects two's-complement signed mode for CPU ops.
  - Implementation: the FSM multiplies magnitudes and negates the product in DONE when the operand signs differ.
  - Latency is unchanged.
  - HW ops are always unsigned.
- MUL_SIGNED_EN undefined: CTL bit3 reads 0 and writes are ignored; all ops are unsigned.

Test Plan:
1. CPU unsigned multiply.
   - Stimulus: OPA=16'h1234, OPB=16'h5678, start at E0.
   - Response: busy=1 until E18; RESHI=16'h0626, RESLO=16'h0060; done=1; with IE=1, irq_mul=1.
2. HW max-value multiply.
   - Stimulus: hw_a=hw_b=16'hFFFF, hw_req high.
   - Response: hw_ack single pulse 17 edges after grant; hw_res=32'hFFFE0001; CPU RES registers unchanged.
3. Same-cycle contention after reset.
   - Stimulus: CPU start and hw_req in the same cycle.
   - Response: CPU granted first (result at E18); HW granted at E19, hw_ack after E36.
   - Then a repeated tie grants HW first.
4. Overrun.
   - Stimulus: second start while busy.
   - Response: STAT.bit0=1; only one result produced; write 1 to STAT.bit0 clears it.
5. Reset mid-operation.
   - Stimulus: assert puc_rst during RUN.
   - Response: all outputs and registers 0, no hw_ack; a fresh op afterwards gives the correct product.
6. Signed mode (MUL_SIGNED_EN).
   - Stimulus: OPA=16'hFFFF, OPB=16'h0002.
   - Response: signed gives 32'hFFFFFFFE; unsigned gives 32'h0001FFFE.
